maxpool_2x2_16_channel: RTL and testbench

Streaming 2x2 max-pool, stride 2, sitting directly downstream of the 16-output-channel 1x1 convolution stage. It consumes one 16-channel pixel per `valid_in` in raster order and keeps a half-width line buffer per channel. It emits one 16-channel pooled pixel per completed 2x2 window, halving both feature-map dimensions before the next convolution layer.

---
 rtl/maxpool_2x2_16_channel_if.sv | 29 ++
 rtl/maxpool_2x2_16_channel.sv | 119 +++++++++++
 tb/tb_maxpool_2x2_16_channel.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_2x2_16_channel_if.sv
// Pixel stream bundle between the 16-channel 1x1 conv stage, the 2x2 max-pool and the next layer.
interface maxpool_2x2_16_channel_if #(
  parameter int unsigned Datawidth = 32
);
  logic                 valid_in;
  logic [Datawidth-1:0] In_0,  In_1,  In_2,  In_3,  In_4,  In_5,  In_6,  In_7;
  logic [Datawidth-1:0] In_8,  In_9,  In_10, In_11, In_12, In_13, In_14, In_15;
  logic                 valid_out;
  logic [Datawidth-1:0] Out_0, Out_1, Out_2,  Out_3,  Out_4,  Out_5,  Out_6,  Out_7;
  logic [Datawidth-1:0] Out_8, Out_9, Out_10, Out_11, Out_12, Out_13, Out_14, Out_15;

  modport master (
    output valid_in,
    output In_0, In_1, In_2, In_3, In_4, In_5, In_6, In_7,
    output In_8, In_9, In_10, In_11, In_12, In_13, In_14, In_15,
    input  valid_out,
    input  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
    input  Out_8, Out_9, Out_10, Out_11, Out_12, Out_13, Out_14, Out_15
  );

  modport slave (
    input  valid_in,
    input  In_0, In_1, In_2, In_3, In_4, In_5, In_6, In_7,
    input  In_8, In_9, In_10, In_11, In_12, In_13, In_14, In_15,
    output valid_out,
    output Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
    output Out_8, Out_9, Out_10, Out_11, Out_12, Out_13, Out_14, Out_15
  );
endinterface

// File: rtl/maxpool_2x2_16_channel.sv
// Streaming 2x2 stride-2 max-pool over 16 signed channels; one pooled pixel per completed window,
// using a per-channel holding register for the row pair and a half-width line buffer for the row above.
module maxpool_2x2_16_channel #(
  parameter int unsigned IMG_Width  = 3,
  parameter int unsigned IMG_Height = 3,
  parameter int unsigned Datawidth  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  maxpool_2x2_16_channel_if.slave  bus
);
  localparam int unsigned NCH     = 16;
  localparam int unsigned WP      = IMG_Width / 2;
  localparam int unsigned CW      = $clog2(IMG_Width);
  localparam int unsigned RW      = $clog2(IMG_Height);
  localparam int unsigned LBW     = (WP > 1) ? $clog2(WP) : 1;
  localparam bit          COL_ODD = (IMG_Width % 2) == 1;
  localparam bit          ROW_ODD = (IMG_Height % 2) == 1;

  typedef logic signed [Datawidth-1:0] smp_t;

  smp_t           in_s      [NCH];
  smp_t           h_q       [NCH];
  smp_t           h_d       [NCH];
  smp_t           out_q     [NCH];
  smp_t           out_d     [NCH];
  smp_t           hmax_c    [NCH];
  smp_t           linebuf_q [WP][NCH];
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           valid_q, valid_d;
  logic           lb_we_c;
  logic [LBW-1:0] lb_idx_c;
  logic           in_region_c;

  assign in_s[0]  = bus.In_0;   assign in_s[1]  = bus.In_1;
  assign in_s[2]  = bus.In_2;   assign in_s[3]  = bus.In_3;
  assign in_s[4]  = bus.In_4;   assign in_s[5]  = bus.In_5;
  assign in_s[6]  = bus.In_6;   assign in_s[7]  = bus.In_7;
  assign in_s[8]  = bus.In_8;   assign in_s[9]  = bus.In_9;
  assign in_s[10] = bus.In_10;  assign in_s[11] = bus.In_11;
  assign in_s[12] = bus.In_12;  assign in_s[13] = bus.In_13;
  assign in_s[14] = bus.In_14;  assign in_s[15] = bus.In_15;

  // The trailing column/row of an odd-sized map is counted but never pooled.
  assign in_region_c = (!COL_ODD || (col_q != CW'(IMG_Width - 1))) &&
                       (!ROW_ODD || (row_q != RW'(IMG_Height - 1)));
  assign lb_idx_c    = LBW'(col_q >> 1);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    out_d   = out_q;
    valid_d = 1'b0;
    lb_we_c = 1'b0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      hmax_c[ch] = (in_s[ch] > h_q[ch]) ? in_s[ch] : h_q[ch];
    end
    if (bus.valid_in) begin
      if (col_q == CW'(IMG_Width - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_Height - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (in_region_c) begin
        if (!col_q[0]) begin
          h_d = in_s;
        end else if (!row_q[0]) begin
          lb_we_c = 1'b1;
        end else begin
          // Bottom-right pixel of a window: fold in the upper row pair from the line buffer.
          valid_d = 1'b1;
          for (int unsigned ch = 0; ch < NCH; ch++) begin
            out_d[ch] = (linebuf_q[lb_idx_c][ch] > hmax_c[ch]) ? linebuf_q[lb_idx_c][ch] : hmax_c[ch];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        h_q[ch]   <= '0;
        out_q[ch] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      h_q     <= h_d;
      out_q   <= out_d;
    end
  end

  // Line buffer is always written on an even row before the odd row reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lb_we_c) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        linebuf_q[lb_idx_c][ch] <= hmax_c[ch];
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.Out_0  = out_q[0];   assign bus.Out_1  = out_q[1];
  assign bus.Out_2  = out_q[2];   assign bus.Out_3  = out_q[3];
  assign bus.Out_4  = out_q[4];   assign bus.Out_5  = out_q[5];
  assign bus.Out_6  = out_q[6];   assign bus.Out_7  = out_q[7];
  assign bus.Out_8  = out_q[8];   assign bus.Out_9  = out_q[9];
  assign bus.Out_10 = out_q[10];  assign bus.Out_11 = out_q[11];
  assign bus.Out_12 = out_q[12];  assign bus.Out_13 = out_q[13];
  assign bus.Out_14 = out_q[14];  assign bus.Out_15 = out_q[15];
endmodule

// File: tb/tb_maxpool_2x2_16_channel.sv
// Bench for the 2x2 max-pool: 4x4, 2x2 and 5x5 instances checked against a window-max reference model.
module tb_maxpool_2x2_16_channel;
  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 16;

  typedef logic signed [DW-1:0] smp_t;
  typedef struct {
    smp_t a [4];
    smp_t b [4];
    smp_t ea;
    smp_t eb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin  [3];
  logic [DW-1:0] din  [NCH];
  logic          vo   [3];
  logic [DW-1:0] dout [3][NCH];
  smp_t          pix  [5][5][NCH];
  smp_t          hold [3][NCH];
  int            dim  [3] = '{4, 2, 5};
  int            got  [$];
  int            e8   [8];
  int            vectors = 0;
  int            errors  = 0;
  vec_t          tbl  [5];

  always #5 clk = ~clk;

  maxpool_2x2_16_channel_if #(.Datawidth(DW)) if4 ();
  maxpool_2x2_16_channel_if #(.Datawidth(DW)) if2 ();
  maxpool_2x2_16_channel_if #(.Datawidth(DW)) if5 ();

  maxpool_2x2_16_channel #(.IMG_Width(4), .IMG_Height(4), .Datawidth(DW)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  maxpool_2x2_16_channel #(.IMG_Width(2), .IMG_Height(2), .Datawidth(DW)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  maxpool_2x2_16_channel #(.IMG_Width(5), .IMG_Height(5), .Datawidth(DW)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  assign if4.valid_in = vin[0]; assign if2.valid_in = vin[1]; assign if5.valid_in = vin[2];
  assign vo[0] = if4.valid_out; assign vo[1] = if2.valid_out; assign vo[2] = if5.valid_out;
  assign if4.In_0 = din[0]; assign if4.In_1 = din[1]; assign if4.In_2 = din[2]; assign if4.In_3 = din[3];
  assign if4.In_4 = din[4]; assign if4.In_5 = din[5]; assign if4.In_6 = din[6]; assign if4.In_7 = din[7];
  assign if4.In_8 = din[8]; assign if4.In_9 = din[9]; assign if4.In_10 = din[10]; assign if4.In_11 = din[11];
  assign if4.In_12 = din[12]; assign if4.In_13 = din[13]; assign if4.In_14 = din[14]; assign if4.In_15 = din[15];
  assign if2.In_0 = din[0]; assign if2.In_1 = din[1]; assign if2.In_2 = din[2]; assign if2.In_3 = din[3];
  assign if2.In_4 = din[4]; assign if2.In_5 = din[5]; assign if2.In_6 = din[6]; assign if2.In_7 = din[7];
  assign if2.In_8 = din[8]; assign if2.In_9 = din[9]; assign if2.In_10 = din[10]; assign if2.In_11 = din[11];
  assign if2.In_12 = din[12]; assign if2.In_13 = din[13]; assign if2.In_14 = din[14]; assign if2.In_15 = din[15];
  assign if5.In_0 = din[0]; assign if5.In_1 = din[1]; assign if5.In_2 = din[2]; assign if5.In_3 = din[3];
  assign if5.In_4 = din[4]; assign if5.In_5 = din[5]; assign if5.In_6 = din[6]; assign if5.In_7 = din[7];
  assign if5.In_8 = din[8]; assign if5.In_9 = din[9]; assign if5.In_10 = din[10]; assign if5.In_11 = din[11];
  assign if5.In_12 = din[12]; assign if5.In_13 = din[13]; assign if5.In_14 = din[14]; assign if5.In_15 = din[15];
  assign dout[0][0] = if4.Out_0; assign dout[0][1] = if4.Out_1; assign dout[0][2] = if4.Out_2; assign dout[0][3] = if4.Out_3;
  assign dout[0][4] = if4.Out_4; assign dout[0][5] = if4.Out_5; assign dout[0][6] = if4.Out_6; assign dout[0][7] = if4.Out_7;
  assign dout[0][8] = if4.Out_8; assign dout[0][9] = if4.Out_9; assign dout[0][10] = if4.Out_10; assign dout[0][11] = if4.Out_11;
  assign dout[0][12] = if4.Out_12; assign dout[0][13] = if4.Out_13; assign dout[0][14] = if4.Out_14; assign dout[0][15] = if4.Out_15;
  assign dout[1][0] = if2.Out_0; assign dout[1][1] = if2.Out_1; assign dout[1][2] = if2.Out_2; assign dout[1][3] = if2.Out_3;
  assign dout[1][4] = if2.Out_4; assign dout[1][5] = if2.Out_5; assign dout[1][6] = if2.Out_6; assign dout[1][7] = if2.Out_7;
  assign dout[1][8] = if2.Out_8; assign dout[1][9] = if2.Out_9; assign dout[1][10] = if2.Out_10; assign dout[1][11] = if2.Out_11;
  assign dout[1][12] = if2.Out_12; assign dout[1][13] = if2.Out_13; assign dout[1][14] = if2.Out_14; assign dout[1][15] = if2.Out_15;
  assign dout[2][0] = if5.Out_0; assign dout[2][1] = if5.Out_1; assign dout[2][2] = if5.Out_2; assign dout[2][3] = if5.Out_3;
  assign dout[2][4] = if5.Out_4; assign dout[2][5] = if5.Out_5; assign dout[2][6] = if5.Out_6; assign dout[2][7] = if5.Out_7;
  assign dout[2][8] = if5.Out_8; assign dout[2][9] = if5.Out_9; assign dout[2][10] = if5.Out_10; assign dout[2][11] = if5.Out_11;
  assign dout[2][12] = if5.Out_12; assign dout[2][13] = if5.Out_13; assign dout[2][14] = if5.Out_14; assign dout[2][15] = if5.Out_15;

  function automatic smp_t smax(input smp_t a, input smp_t b);
    return (a > b) ? a : b;
  endfunction

  // Reference: when (r,k) closes a window, the pooled value is the max of its four pixels.
  task automatic check_cycle(input int sel, input int r, input int k, input bit pulse);
    bit ev;
    int badc;
    for (int d = 0; d < 3; d++) begin
      ev = pulse && (d == sel);
      if (ev) begin
        for (int c = 0; c < NCH; c++) begin
          hold[d][c] = smax(smax(pix[r-1][k-1][c], pix[r-1][k][c]), smax(pix[r][k-1][c], pix[r][k][c]));
        end
      end
      badc = -1;
      for (int c = NCH - 1; c >= 0; c--) begin
        if (dout[d][c] !== hold[d][c]) badc = c;
      end
      vectors++;
      if (vo[d] !== ev) begin
        errors++;
        $display("FAIL valid dut%0d px(%0d,%0d): got %b want %b", d, r, k, vo[d], ev);
      end else if (badc >= 0) begin
        errors++;
        $display("FAIL out dut%0d ch%0d px(%0d,%0d): got %0d want %0d", d, badc, r, k,
                 $signed(dout[d][badc]), hold[d][badc]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 3; d++) vin[d] = 1'b0;
      for (int c = 0; c < NCH; c++) din[c] = $urandom;
      @(posedge clk); #1;
      check_cycle(-1, 0, 0, 1'b0);
    end
  endtask

  // gap < 0 picks a random 0..2 idle cycles after every pixel.
  task automatic send_frame(input int sel, input int npix, input int gap);
    int w, pulses, g, r, k;
    bit pl;
    w = dim[sel];
    pulses = 0;
    for (int p = 0; p < npix; p++) begin
      r = p / w;
      k = p % w;
      for (int c = 0; c < NCH; c++) din[c] = pix[r][k][c];
      vin[sel] = 1'b1;
      @(posedge clk); #1;
      pl = (r % 2 == 1) && (k % 2 == 1) && (r < 2 * (w / 2)) && (k < 2 * (w / 2));
      check_cycle(sel, r, k, pl);
      if (vo[sel] === 1'b1) begin
        pulses++;
        got.push_back(int'($signed(dout[sel][0])));
      end
      vin[sel] = 1'b0;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (p != npix - 1) idle(g);
    end
    if (npix == w * w) begin
      vectors++;
      if (pulses != (w / 2) * (w / 2)) begin
        errors++;
        $display("FAIL pulse count dut%0d: got %0d want %0d", sel, pulses, (w / 2) * (w / 2));
      end
    end
  endtask

  task automatic check_seq(input string name, input int n);
    vectors++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL %s count: got %0d pulses want %0d", name, got.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (got[i] != e8[i]) begin
          errors++;
          $display("FAIL %s pulse%0d: got %0d want %0d", name, i, got[i], e8[i]);
        end
      end
    end
    got.delete();
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (vo[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s valid dut%0d: got %b want 0", name, d, vo[d]);
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (dout[d][c] !== '0) begin
            errors++;
            $display("FAIL %s out dut%0d ch%0d: got %0d want 0", name, d, c, $signed(dout[d][c]));
            break;
          end
        end
      end
      for (int c = 0; c < NCH; c++) hold[d][c] = '0;
    end
  endtask

  task automatic fill_ramp(input int base, input int w);
    for (int r = 0; r < w; r++)
      for (int k = 0; k < w; k++)
        for (int c = 0; c < NCH; c++) pix[r][k][c] = smp_t'(base + r * w + k + 100 * c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 5; k++)
        for (int c = 0; c < NCH; c++) begin
          case ($urandom_range(0, 7))
            0: pix[r][k][c] = 32'sh7fffffff;
            1: pix[r][k][c] = 32'sh80000000;
            2: pix[r][k][c] = -32'sd1;
            3: pix[r][k][c] = (k > 0) ? pix[r][k-1][c] : 32'sd0;
            default: pix[r][k][c] = smp_t'($urandom);
          endcase
        end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0].a = '{-5, 3, -2, -7};       tbl[0].b = '{-9, -4, -8, -6};   tbl[0].ea = 3;  tbl[0].eb = -4;
    tbl[1].a = '{-1, -1, -1, -1};      tbl[1].b = '{-1, -1, -1, -1};   tbl[1].ea = -1; tbl[1].eb = -1;
    tbl[2].a = '{32'sh7fffffff, 32'sh80000000, 0, -1};
    tbl[2].b = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
    tbl[2].ea = 32'sh7fffffff;         tbl[2].eb = 32'sh80000000;
    tbl[3].a = '{1, 2, 3, 4};          tbl[3].b = '{4, 3, 2, 1};       tbl[3].ea = 4;  tbl[3].eb = 4;
    tbl[4].a = '{-100, -100, -99, -101}; tbl[4].b = '{7, 7, 7, 7};     tbl[4].ea = -99; tbl[4].eb = 7;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    for (int c = 0; c < NCH; c++) din[c] = '0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp, continuous valid
    got.delete();
    fill_ramp(0, 4);
    send_frame(0, 16, 0);
    e8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_seq("ramp4", 4);
    idle(3);

    // signed compare and tie cases on the 2x2 instance
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 4; j++) begin
        pix[j / 2][j % 2][0] = tbl[t].a[j];
        for (int c = 1; c < NCH; c++) pix[j / 2][j % 2][c] = tbl[t].b[j];
      end
      send_frame(1, 4, 0);
      vectors++;
      if (dout[1][0] !== tbl[t].ea) begin
        errors++;
        $display("FAIL signed tbl%0d ch0: got %0d want %0d", t, $signed(dout[1][0]), tbl[t].ea);
      end else begin
        for (int c = 1; c < NCH; c++) begin
          if (dout[1][c] !== tbl[t].eb) begin
            errors++;
            $display("FAIL signed tbl%0d ch%0d: got %0d want %0d", t, c, $signed(dout[1][c]), tbl[t].eb);
            break;
          end
        end
      end
      idle(t % 2);
    end
    got.delete();

    // gapped 4x4 ramp: valid 1,0,0,1,...
    fill_ramp(0, 4);
    send_frame(0, 16, 2);
    e8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_seq("gapped4", 4);

    // odd 5x5 followed immediately by a random 5x5 frame
    fill_ramp(0, 5);
    send_frame(2, 25, 0);
    e8 = '{6, 8, 16, 18, 0, 0, 0, 0};
    check_seq("odd5", 4);
    fill_rand();
    send_frame(2, 25, 0);
    got.delete();
    idle(2);

    // back-to-back 4x4 frames
    fill_ramp(0, 4);
    send_frame(0, 16, 0);
    fill_ramp(1000, 4);
    send_frame(0, 16, 0);
    e8 = '{5, 7, 13, 15, 1005, 1007, 1013, 1015};
    check_seq("b2b4", 8);

    // randomized frames on random instances with random gaps
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      fill_rand();
      send_frame(sel, dim[sel] * dim[sel], -1);
      idle(int'($urandom_range(0, 2)));
    end
    got.delete();

    // asynchronous reset after 9 pixels of a 4x4 frame
    fill_ramp(0, 4);
    send_frame(0, 9, 0);
    vin[0] = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    got.delete();
    send_frame(0, 16, 0);
    e8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_seq("after_reset", 4);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
